// File: rtl/cpu_sequencer.sv
// Multi-cycle sequencer for the 8-bit teaching CPU: owns the PC and walks each instruction
// through FETCH/DECODE/EXEC/WB. Optional breakpoint logic is enabled by defining BREAKPOINT_EN.
module cpu_sequencer #(
    parameter int         PC_W     = 16,
    parameter int         IMEM_LAT = 1,
    parameter logic [3:0] HALT_OP  = 4'hF
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            run,
    input  logic            step,
    input  logic [15:0]     ir,
    input  logic            write_req,
    input  logic            jump,
    input  logic [PC_W-1:0] jump_target,
`ifdef BREAKPOINT_EN
    input  logic [PC_W-1:0] bp_addr,
    input  logic            bp_en,
    output logic            bp_hit,
`endif
    output logic [PC_W-1:0] pc,
    output logic [15:0]     ir_q,
    output logic            alu_en,
    output logic            rf_we,
    output logic            halted,
    output logic [2:0]      state,
    output logic [15:0]     instr_cnt
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_EXEC   = 3'd3,
        S_WB     = 3'd4,
        S_HALT   = 3'd5
    } state_t;

    localparam logic [1:0] FETCH_LAST = 2'(IMEM_LAT);

    state_t          r_state;
    logic [1:0]      r_wait;
    logic            r_step_q;
    logic [PC_W-1:0] r_pc;
    logic [15:0]     r_ir_q;
    logic            r_alu_en;
    logic            r_rf_we;
    logic            r_halted;
    logic [15:0]     r_cnt;

    logic            w_step_edge;
    logic [PC_W-1:0] w_pc_next;

    assign w_step_edge = step & ~r_step_q;
    assign w_pc_next   = jump ? jump_target : r_pc + PC_W'(1);

`ifdef BREAKPOINT_EN
    logic r_bp_hit;
    logic w_bp_idle;
    logic w_bp_wb;

    assign w_bp_idle = bp_en && (r_pc == bp_addr);
    assign w_bp_wb   = bp_en && (w_pc_next == bp_addr);
    assign bp_hit    = r_bp_hit;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state  <= S_IDLE;
            r_wait   <= 2'd0;
            r_step_q <= 1'b1;  // a button held through reset release is not an edge
            r_pc     <= '0;
            r_ir_q   <= 16'd0;
            r_alu_en <= 1'b0;
            r_rf_we  <= 1'b0;
            r_halted <= 1'b0;
            r_cnt    <= 16'd0;
`ifdef BREAKPOINT_EN
            r_bp_hit <= 1'b0;
`endif
        end else begin
            r_step_q <= step;
            r_alu_en <= 1'b0;
            r_rf_we  <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    r_wait <= 2'd0;
`ifdef BREAKPOINT_EN
                    // A step always fetches without a compare; it also releases a held breakpoint.
                    if (w_step_edge) begin
                        r_state  <= S_FETCH;
                        r_bp_hit <= 1'b0;
                    end else if (run && !r_bp_hit) begin
                        if (w_bp_idle) r_bp_hit <= 1'b1;
                        else           r_state  <= S_FETCH;
                    end
`else
                    if (run || w_step_edge) r_state <= S_FETCH;
`endif
                end
                S_FETCH: begin
                    if (r_wait == FETCH_LAST) begin
                        r_ir_q  <= ir;
                        r_wait  <= 2'd0;
                        r_state <= S_DECODE;
                    end else begin
                        r_wait <= r_wait + 2'd1;
                    end
                end
                S_DECODE: begin
                    if (r_ir_q[15:12] == HALT_OP) begin
                        r_state  <= S_HALT;
                        r_halted <= 1'b1;
                    end else begin
                        r_state  <= S_EXEC;
                        r_alu_en <= 1'b1;
                    end
                end
                S_EXEC: begin
                    r_state <= S_WB;
                    r_rf_we <= write_req;
                end
                S_WB: begin
                    r_pc  <= w_pc_next;
                    r_cnt <= r_cnt + 16'd1;
`ifdef BREAKPOINT_EN
                    if (run && w_bp_wb) begin
                        r_state  <= S_IDLE;
                        r_bp_hit <= 1'b1;
                    end else begin
                        r_state <= run ? S_FETCH : S_IDLE;
                    end
`else
                    r_state <= run ? S_FETCH : S_IDLE;
`endif
                end
                S_HALT: begin
                    r_halted <= 1'b1;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign pc        = r_pc;
    assign ir_q      = r_ir_q;
    assign alu_en    = r_alu_en;
    assign rf_we     = r_rf_we;
    assign halted    = r_halted;
    assign state     = r_state;
    assign instr_cnt = r_cnt;

endmodule

// File: doc/cpu_sequencer.md
Name: cpu_sequencer

Overview:
Multi-cycle control unit for the 8-bit teaching CPU. It replaces the free PC counter that is driven by a debounced button.
- Owns the PC and sequences each instruction through fetch from the instruction BRAM, decode, ALU execute and register-bank write-back.
- Supports free-run mode and single-step mode, where one debounced button press executes one instruction.
- Stops permanently on a HALT opcode.

Parameters:
PC_W, 16, width of PC / instruction address
IMEM_LAT, 1, cycles from stable PC to valid instruction memory output (legal 1..3)
HALT_OP, 4'hF, opcode value in ir[15:12] that halts the core

Ports:
clk  input  1  system clock (clk_5 domain)
reset  input  1  asynchronous, active-low reset
run  input  1  1 = free-run, 0 = single-step
step  input  1  debounced step button level
ir  input  16  instruction memory output
write_req  input  1  from Decoder: current instruction writes the register bank
jump  input  1  from Decoder: current instruction is a jump
jump_target  input  PC_W  jump destination
pc  output  PC_W  instruction address to instruction memory
ir_q  output  16  latched instruction, to Decoder
alu_en  output  1  one-cycle ALU enable / flag-capture strobe
rf_we  output  1  one-cycle register-bank write strobe
halted  output  1  core halted
state  output  3  current FSM state, for LED/7-seg debug
instr_cnt  output  16  retired instruction count

Behaviour:
- Reset (reset=0, asynchronous, takes effect immediately):
  - pc=0, ir_q=0, state=IDLE, alu_en=0, rf_we=0, halted=0, instr_cnt=0.
  - Internal step_q=1, so a step held high through reset release does not trigger.
  - Reset asserted mid-instruction abandons that instruction. No strobe may be emitted in the reset cycle.
- State encodings: IDLE=0, FETCH=1, DECODE=2, EXEC=3, WB=4, HALT=5. Codes 6 and 7 go to IDLE.
- Step edge: step_edge = step & ~step_q, with step_q registered every cycle. Edges outside IDLE are ignored and not queued.
- IDLE:
  - run=1 -> FETCH.
  - Otherwise step_edge -> FETCH.
  - Otherwise stay in IDLE.
- FETCH:
  - pc held stable for exactly IMEM_LAT+1 cycles, using an internal wait counter cleared on entry.
  - ir_q <= ir on the final FETCH edge, then -> DECODE.
- DECODE: 1 cycle.
  - ir_q[15:12]==HALT_OP -> HALT.
  - Otherwise -> EXEC.
- EXEC: 1 cycle, alu_en=1, then -> WB.
- WB: 1 cycle.
  - rf_we = write_req.
  - pc <= jump ? jump_target : pc+1. Increment wraps modulo 2^PC_W.
  - instr_cnt <= instr_cnt+1, wrapping at 16'hFFFF -> 0.
  - Next state: FETCH if run=1, otherwise IDLE.
- HALT:
  - halted=1; pc and instr_cnt frozen; no strobes.
  - Ignores run and step. Exit only by reset.
  - HALT does not count as a retired instruction.
- Strobes alu_en and rf_we are registered outputs, high for exactly one cycle per instruction. rf_we is never high when write_req=0.
- Run-mode throughput: IMEM_LAT+4 cycles per instruction (5 with default).
- run dropping mid-instruction: the current instruction completes, then the FSM goes to IDLE. run rising in IDLE: FETCH on the next cycle.
- ir_q changes only on the FETCH exit edge; Decoder outputs are stable through DECODE/EXEC/WB.

Optional Feature:
BREAKPOINT_EN
- When defined, adds input bp_addr [PC_W-1:0], input bp_en [1], and output bp_hit [1], reset 0.
- On an IDLE->FETCH or WB->FETCH transition with run=1, bp_en=1 and next pc==bp_addr, the FSM goes to IDLE instead. bp_hit sets and stays 1.
- bp_hit clears on the next step_edge. That step executes the breakpointed instruction.
- A breakpoint never fires on single-step fetches.
- When not defined: no extra ports, no compare logic, behaviour exactly as above.

Test Plan:
1. Reset release, run=1, ir=16'h1234 (non-halt), write_req=0, jump=0:
   - pc steps 0->1->2 every 5 cycles; alu_en high one cycle per instruction; rf_we stays 0; instr_cnt=2 after 10 cycles in run.
2. run=0, step held high 20 cycles then low:
   - exactly one instruction; pc 0->1; instr_cnt=1; state returns to 0.
   - A second press gives pc=2. Step held high through reset release executes nothing.
3. write_req=1 on one instruction:
   - rf_we high exactly one cycle, coincident with state=4, one cycle after alu_en.
   - Next instruction with write_req=0: no rf_we.
4. jump=1 with jump_target=16'h0010 at pc=5 -> pc=16'h0010.
   - Separately, pc=16'hFFFF with jump=0 -> pc=16'h0000.
5. ir=16'hF000 fetched at pc=3:
   - state=5, halted=1, pc stays 3, no alu_en/rf_we, instr_cnt unchanged.
   - Toggling run/step has no effect; reset=0 returns all outputs to reset values.
6. Reset asserted while state=3:
   - alu_en, rf_we, pc, state and instr_cnt go to 0 in the same cycle without waiting for clk.
   - After release with run=1, fetch restarts at pc=0.
